// File: rtl/hci_core_tracked_mixer_pkg.sv
// Shared types and helpers for the tracked HCI core mixer.
// Default widths mirror the HCI defaults.
package hci_core_tracked_mixer_pkg;

    localparam int unsigned HCI_DEFAULT_DW = 32;
    localparam int unsigned HCI_DEFAULT_AW = 32;
    localparam int unsigned HCI_DEFAULT_BW = 8;
    localparam int unsigned HCI_DEFAULT_WW = 32;
    localparam int unsigned HCI_DEFAULT_OW = 1;
    localparam int unsigned HCI_DEFAULT_UW = 1;

    typedef enum logic {
        HCI_MIXER_RR,
        HCI_MIXER_FIXED
    } hci_mixer_arb_e;

    // Index width for N items, never below one bit.
    function automatic int unsigned hci_idx_width(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/hci_core_mixer_id_fifo.sv
// In-order FIFO of issuing-port indices for granted transactions.
// The head is readable combinationally so responses route with zero latency.
module hci_core_mixer_id_fifo
    import hci_core_tracked_mixer_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned IDW   = 1
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         i_clear,
    input  logic                         i_push,
    input  logic                         i_pop,
    input  logic [IDW-1:0]               i_data,
    output logic [IDW-1:0]               o_data,
    output logic                         o_full,
    output logic                         o_empty,
    output logic [$clog2(DEPTH+1)-1:0]   o_count
);

    localparam int unsigned PW = hci_idx_width(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [IDW-1:0] r_mem [DEPTH];
    logic [PW-1:0]  r_wr_ptr;
    logic [PW-1:0]  r_rd_ptr;
    logic [CW-1:0]  r_count;
    logic           w_push;
    logic           w_pop;

    assign o_full  = (r_count == CW'(DEPTH));
    assign o_empty = (r_count == '0);
    assign w_push  = i_push & ~o_full;
    assign w_pop   = i_pop & ~o_empty;
    assign o_data  = r_mem[r_rd_ptr];
    assign o_count = r_count;

    // Explicit wrap so non-power-of-2 depths stay inside the buffer.
    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= next_ptr(r_wr_ptr);
            end
            if (w_pop) begin
                r_rd_ptr <= next_ptr(r_rd_ptr);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CW'(1);
            end else if (w_pop && !w_push) begin
                r_count <= r_count - CW'(1);
            end
        end
    end

endmodule

// File: rtl/hci_core_tracked_mixer.sv
// N-to-1 HCI core mixer: arbitrates initiators onto one target and returns
// each response to the port that issued it, using an in-order ID FIFO.
module hci_core_tracked_mixer
    import hci_core_tracked_mixer_pkg::*;
#(
    parameter int unsigned    NB_CHAN         = 2,
    parameter int unsigned    DW              = HCI_DEFAULT_DW,
    parameter int unsigned    AW              = HCI_DEFAULT_AW,
    parameter int unsigned    BW              = HCI_DEFAULT_BW,
    parameter int unsigned    WW              = HCI_DEFAULT_WW,
    parameter int unsigned    OW              = HCI_DEFAULT_OW,
    parameter int unsigned    UW              = HCI_DEFAULT_UW,
    parameter int unsigned    MAX_OUTSTANDING = 4,
    parameter hci_mixer_arb_e ARB_MODE        = HCI_MIXER_RR
) (
    input  logic                                    clk_i,
    input  logic                                    rst_ni,
    input  logic                                    clear_i,
    // initiator ports
    input  logic [NB_CHAN-1:0]                      i_in_req,
    output logic [NB_CHAN-1:0]                      o_in_gnt,
    input  logic [NB_CHAN-1:0][AW-1:0]              i_in_add,
    input  logic [NB_CHAN-1:0]                      i_in_wen,
    input  logic [NB_CHAN-1:0][DW-1:0]              i_in_data,
    input  logic [NB_CHAN-1:0][DW/BW-1:0]           i_in_be,
    input  logic [NB_CHAN-1:0][(DW/WW)*OW-1:0]      i_in_boffs,
    input  logic [NB_CHAN-1:0][UW-1:0]              i_in_user,
    input  logic [NB_CHAN-1:0]                      i_in_lrdy,
    output logic [NB_CHAN-1:0][DW-1:0]              o_in_r_data,
    output logic [NB_CHAN-1:0]                      o_in_r_valid,
    output logic [NB_CHAN-1:0]                      o_in_r_opc,
    output logic [NB_CHAN-1:0][UW-1:0]              o_in_r_user,
    // shared target port
    output logic                                    o_out_req,
    input  logic                                    i_out_gnt,
    output logic [AW-1:0]                           o_out_add,
    output logic                                    o_out_wen,
    output logic [DW-1:0]                           o_out_data,
    output logic [DW/BW-1:0]                        o_out_be,
    output logic [(DW/WW)*OW-1:0]                   o_out_boffs,
    output logic [UW-1:0]                           o_out_user,
    output logic                                    o_out_lrdy,
    input  logic [DW-1:0]                           i_out_r_data,
    input  logic                                    i_out_r_valid,
    input  logic                                    i_out_r_opc,
    input  logic [UW-1:0]                           i_out_r_user,
    // status
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0]    outstanding_o,
    output logic                                    busy_o,
    output logic                                    err_o
);

    localparam int unsigned IDW = hci_idx_width(NB_CHAN);

    logic [IDW-1:0] r_rr_ptr;
    logic           r_err;
    logic [IDW-1:0] w_winner;
    logic [IDW-1:0] w_head;
    logic           w_found;
    logic           w_full;
    logic           w_empty;
    logic           w_hs;
    logic           w_stray;

    // Scan order starts at rr_ptr (RR) or 0 (FIXED); the start index also
    // drives the payload when nobody requests.
    always_comb begin
        int v_idx;
        w_winner = (ARB_MODE == HCI_MIXER_RR) ? r_rr_ptr : '0;
        w_found  = 1'b0;
        v_idx    = 0;
        for (int i = 0; i < int'(NB_CHAN); i++) begin
            if (ARB_MODE == HCI_MIXER_RR) begin
                v_idx = int'(r_rr_ptr) + i;
                if (v_idx >= int'(NB_CHAN)) begin
                    v_idx = v_idx - int'(NB_CHAN);
                end
            end else begin
                v_idx = i;
            end
            if (!w_found && i_in_req[v_idx]) begin
                w_winner = IDW'(v_idx);
                w_found  = 1'b1;
            end
        end
    end

    assign o_out_req   = (|i_in_req) & ~w_full;
    assign w_hs        = o_out_req & i_out_gnt;
    assign w_stray     = i_out_r_valid & w_empty;

    assign o_out_add   = i_in_add[w_winner];
    assign o_out_wen   = i_in_wen[w_winner];
    assign o_out_data  = i_in_data[w_winner];
    assign o_out_be    = i_in_be[w_winner];
    assign o_out_boffs = i_in_boffs[w_winner];
    assign o_out_user  = i_in_user[w_winner];
    assign o_out_lrdy  = i_in_lrdy[w_winner];

    for (genvar gi = 0; gi < NB_CHAN; gi++) begin : g_port
        logic w_rsp_sel;
        assign w_rsp_sel          = i_out_r_valid & ~w_empty & (w_head == IDW'(gi));
        assign o_in_gnt[gi]       = (w_winner == IDW'(gi)) & i_out_gnt & ~w_full;
        assign o_in_r_valid[gi]   = w_rsp_sel;
        assign o_in_r_data[gi]    = w_rsp_sel ? i_out_r_data : '0;
        assign o_in_r_opc[gi]     = w_rsp_sel & i_out_r_opc;
        assign o_in_r_user[gi]    = w_rsp_sel ? i_out_r_user : '0;
    end

    hci_core_mixer_id_fifo #(
        .DEPTH (MAX_OUTSTANDING),
        .IDW   (IDW)
    ) u_id_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .i_clear (clear_i),
        .i_push  (w_hs),
        .i_pop   (i_out_r_valid),
        .i_data  (w_winner),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (outstanding_o)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rr_ptr <= '0;
            r_err    <= 1'b0;
        end else if (clear_i) begin
            r_rr_ptr <= '0;
            r_err    <= 1'b0;
        end else begin
            if (w_hs && ARB_MODE == HCI_MIXER_RR) begin
                r_rr_ptr <= (w_winner == IDW'(NB_CHAN - 1)) ? '0 : w_winner + IDW'(1);
            end
            if (w_stray) begin
                r_err <= 1'b1;
            end
        end
    end

    assign busy_o = (outstanding_o != '0);
    assign err_o  = r_err;

endmodule
